// File: rtl/multiples_sequencer_if.sv
// rtl/multiples_sequencer_if.sv - registered row stream from the multiples sequencer to the row-by-vector modules
interface multiples_sequencer_if #(
  parameter int data_width  = 12,
  parameter int index_width = 12
) ();
  logic [data_width-1:0]  out_data;
  logic [index_width-1:0] out_index;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/multiples_sequencer.sv
// rtl/multiples_sequencer.sv - walks the multiples memory over a row range and streams each row out
module multiples_sequencer #(
  parameter int no_of_row_by_vector_modules  = 4,
  parameter int memory_A_height              = 2000,
  parameter int address_width                = $clog2(memory_A_height) + 1,
  parameter int multiples_memory_value_width = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [address_width-1:0] base_address,
  input  logic [address_width-1:0] row_count,
  output logic [address_width-1:0] multiples_read_address,
  input  logic [multiples_memory_value_width*no_of_row_by_vector_modules-1:0] multiples_input,
  multiples_sequencer_if.master    row,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [address_width:0]   last_limit = (address_width + 1)'(memory_A_height);
  localparam logic [address_width:0]   one_wide   = (address_width + 1)'(1);
  localparam logic [address_width-1:0] one        = address_width'(1);

  state_t                   state, state_next;
  logic [address_width-1:0] addr, idx, remaining;
  logic [address_width:0]   last;
  logic                     load, accept, cmd_take, error_next;

  // One extra bit so base + count - 1 cannot wrap past the top of memory.
  assign last = {1'b0, base_address} + {1'b0, row_count} - one_wide;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    cmd_take   = 1'b0;
    error_next = 1'b0;
    accept     = row.out_valid && row.out_ready;
    case (state)
      IDLE: begin
        if (start) begin
          if (row_count == '0) begin
            state_next = DONE;
          end else if (last > last_limit) begin
            error_next = 1'b1;
          end else begin
            cmd_take   = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        load = !row.out_valid || row.out_ready;
        if (load && remaining == one) state_next = DRAIN;
      end
      DRAIN: begin
        if (accept) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      idx           <= '0;
      remaining     <= '0;
      error         <= 1'b0;
      row.out_valid <= 1'b0;
      row.out_data  <= '0;
      row.out_index <= '0;
    end else begin
      state <= state_next;
      error <= error_next;
      if (cmd_take) begin
        addr      <= base_address;
        idx       <= '0;
        remaining <= row_count;
      end
      if (load) begin
        row.out_data  <= multiples_input;
        row.out_index <= idx;
        row.out_valid <= 1'b1;
        idx           <= idx + one;
        remaining     <= remaining - one;
        // The final row leaves the address parked so DRAIN keeps presenting it.
        if (remaining != one) addr <= addr + one;
      end
      if (state == DRAIN && accept) row.out_valid <= 1'b0;
    end
  end

  assign busy                   = (state == RUN) || (state == DRAIN);
  assign done                   = (state == DONE);
  assign multiples_read_address = busy ? addr : '0;
endmodule

// File: tb/tb_multiples_sequencer.sv
// tb/tb_multiples_sequencer.sv - scoreboard bench for multiples_sequencer
module tb_multiples_sequencer;
  localparam int aw     = 12;
  localparam int dw     = 12;
  localparam int height = 2000;

  typedef struct packed {
    logic [dw-1:0] d;
    logic [aw-1:0] i;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [aw-1:0] base_address, row_count, multiples_read_address;
  logic [dw-1:0] multiples_input;
  logic          busy, done, error;
  logic [dw-1:0] mem [0:height];

  multiples_sequencer_if #(.data_width(dw), .index_width(aw)) ifc ();

  multiples_sequencer #(
    .no_of_row_by_vector_modules(4),
    .memory_A_height(height),
    .address_width(aw),
    .multiples_memory_value_width(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_address(base_address),
    .row_count(row_count),
    .multiples_read_address(multiples_read_address),
    .multiples_input(multiples_input),
    .row(ifc),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  assign multiples_input = (multiples_read_address <= aw'(height)) ? mem[multiples_read_address] : '0;

  int    cyc = 0;
  int    n_start = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    done_cnt = 0;
  int    err_cnt = 0;
  int    last_acc = 0;
  beat_t beat_q[$];
  int    done_q[$];
  int    err_q[$];
  logic [31:0] pat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic bad(input string nm, input int act, input int req);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a beat or pulses done/error.
  logic          prev_hold = 1'b0;
  logic [dw-1:0] prev_data;
  logic [aw-1:0] prev_index;
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", ifc.out_valid, 1'b1);
        chk("hold_data", ifc.out_data, prev_data);
        chk("hold_index", ifc.out_index, prev_index);
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (beat_q.size() == 0) begin
          bad("extra_beat", 1, 0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_data", ifc.out_data, b.d);
          chk("beat_index", ifc.out_index, b.i);
        end
        last_acc = cyc;
      end
      prev_hold  = ifc.out_valid && !ifc.out_ready;
      prev_data  = ifc.out_data;
      prev_index = ifc.out_index;
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          bad("extra_done", 1, 0);
        end else begin
          int e;
          e = done_q.pop_front();
          if (e < 0) chk("done_after_accept", cyc, last_acc + 1);
          else       chk("done_cycle", cyc - n_start, e);
        end
      end
      if (error) begin
        err_cnt++;
        if (err_q.size() == 0) begin
          bad("extra_error", 1, 0);
        end else begin
          int e;
          e = err_q.pop_front();
          chk("error_cycle", cyc - n_start, e);
        end
      end
    end
  end

  function automatic bit rejected(input int b, input int r);
    return (r != 0) && (b + r - 1 > height);
  endfunction

  // Reference: an accepted command yields rows mem[b..b+r-1] at offsets 0..r-1, then one done.
  task automatic push_expect(input int b, input int r, input int done_off);
    if (rejected(b, r)) begin
      err_q.push_back(0);
    end else begin
      for (int k = 0; k < r; k++) begin
        beat_t e;
        e.d = mem[b + k];
        e.i = aw'(k);
        beat_q.push_back(e);
      end
      done_q.push_back(r == 0 ? 0 : done_off);
    end
  endtask

  task automatic issue(input int b, input int r);
    @(posedge clk); #1;
    start        = 1'b1;
    base_address = aw'(b);
    row_count    = aw'(r);
    @(posedge clk); #1;
    start   = 1'b0;
    n_start = cyc;
  endtask

  // Full-throughput run with cycle-exact checks; j0/j1 inject ignored starts in those cycles.
  task automatic run_timed(input int b, input int r, input int j0, input int j1);
    bit acc;
    acc = !rejected(b, r) && r != 0;
    push_expect(b, r, r + 1);
    ifc.out_ready = 1'b1;
    issue(b, r);
    for (int c = 0; c <= r + 2; c++) begin
      @(negedge clk);
      chk("busy", busy, acc && c <= r);
      chk("out_valid", ifc.out_valid, acc && c >= 1 && c <= r);
      chk("read_address", multiples_read_address,
          (acc && c <= r) ? aw'(b + (c < r ? c : r - 1)) : aw'(0));
      @(posedge clk); #1;
      start = (c + 1 == j0) || (c + 1 == j1);
      if (start) begin
        base_address = aw'(500);
        row_count    = aw'($urandom_range(1, 8));
      end
    end
    start = 1'b0;
  endtask

  // Run under back-pressure: mode 1 follows pat (bit c-1 drives cycle c), mode 0 is random.
  task automatic run_wait(input int b, input int r, input int mode);
    bit rej, seen;
    int d0, e0, budget;
    rej    = rejected(b, r);
    d0     = done_cnt;
    e0     = err_cnt;
    budget = 8 * r + 20;
    seen   = 1'b0;
    push_expect(b, r, -1);
    ifc.out_ready = 1'b1;
    issue(b, r);
    for (int c = 1; c <= budget && !seen; c++) begin
      @(posedge clk); #1;
      if (mode == 1) ifc.out_ready = (c <= 32) ? pat[c-1] : 1'b1;
      else           ifc.out_ready = 1'($urandom_range(0, 1));
      seen = rej ? (err_cnt != e0) : (done_cnt != d0);
    end
    if (!seen) bad(rej ? "error_timeout" : "done_timeout", 0, 1);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    base_address  = '0;
    row_count     = '0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i <= height; i++) mem[i] = dw'(i);

    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", ifc.out_valid, 1'b0);
    chk("rst_data", ifc.out_data, 0);
    chk("rst_index", ifc.out_index, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_addr", multiples_read_address, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_timed(10, 4, -1, -1);
    pat = 32'hFFFF_FFF9;
    run_wait(0, 3, 1);
    run_timed(7, 0, -1, -1);
    run_timed(1998, 3, -1, -1);
    run_timed(1999, 3, -1, -1);
    run_timed(100, 8, 3, 9);

    // A rejected start frees the block in time for a start held into the very next cycle.
    push_expect(1999, 3, 0);
    @(posedge clk); #1;
    start = 1'b1; base_address = aw'(1999); row_count = aw'(3);
    @(posedge clk); #1;
    n_start = cyc;
    base_address = aw'(5); row_count = aw'(2);
    push_expect(5, 2, 3);
    @(posedge clk); #1;
    start   = 1'b0;
    n_start = cyc;
    @(negedge clk);
    chk("busy_after_error", busy, 1'b1);
    chk("addr_after_error", multiples_read_address, 5);
    repeat (5) @(posedge clk);
    #1;

    // Reset while the second beat is stalled.
    push_expect(40, 6, 7);
    issue(40, 6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    reset         = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", ifc.out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_addr", multiples_read_address, 0);
    chk("midrst_done", done, 1'b0);
    beat_q.delete();
    done_q.delete();
    repeat (5) @(posedge clk);
    #1;
    run_timed(33, 5, -1, -1);

    for (int i = 0; i <= height; i++) mem[i] = dw'($urandom);
    for (int n = 0; n < 40; n++) begin
      int b, r;
      case ($urandom_range(0, 3))
        0:       b = height - $urandom_range(0, 10);
        default: b = $urandom_range(0, height);
      endcase
      r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      if ($urandom_range(0, 2) == 0) run_timed(b, r, -1, -1);
      else                           run_wait(b, r, 0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("beats_left", beat_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    chk("errors_left", err_q.size(), 0);
    chk("final_busy", busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
